bus_arb: RTL and testbench
==========================

Name: bus_arb

Overview:
- Registered arbiter for the single 8-bit internal data bus.
- Shares the bus between NREQ requesters: requester 0 is the control unit, requester 1 is the DMA/IO engine, requester 2 is the debug port.
- Each requester supplies its own bus-driver select (outflags code) and load-enable select (inflags code). The arbiter forwards only the granted requester's codes to the datapath.
- Round-robin arbitration, with optional locked bursts bounded by MAXBURST.

Parameters:
- NREQ, 3, number of requesters (2..4).
- MAXBURST, 4, max consecutive cycles one requester keeps a locked grant while others wait (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester bus request, level.
- lock  in  NREQ  per-requester burst hold; meaningful only while that requester is granted.
- src_sel  in  NREQ*4  packed outflags codes; requester i occupies bits [4i+3:4i].
- dst_sel  in  NREQ*5  packed inflags codes; requester i occupies bits [5i+4:5i].
- gnt  out  NREQ  one-hot grant, registered.
- outflags  out  4  bus driver select to datapath; 0 = no driver.
- inflags  out  5  bus load select to datapath; 0 = no load.
- busy  out  1  high while any grant is active.
- burst_cnt  out  4  cycles elapsed in the current grant, saturating.

Behaviour:
- Reset (reset=0, asynchronous) forces the following, regardless of clk:
  - gnt=0, outflags=0, inflags=0, busy=0, burst_cnt=0.
  - Round-robin pointer rr=0 (requester 0 is checked first).
  - State is IDLE.
- States: IDLE, GRANT.
- IDLE:
  - Each cycle, if any req is high, select the first set req scanning from rr upward with wrap at NREQ.
  - Next edge: gnt[w]=1, state=GRANT, burst_cnt=1.
  - Latency is 1 cycle from req sampled high to gnt high.
- GRANT, owner w. At each rising edge, evaluate in this priority order:
  1. req[w]=0: release. gnt=0, rr=w+1 mod NREQ, state=IDLE. There is no idle bubble if another requester is waiting: re-arbitrate in the same edge and grant the winner directly, with burst_cnt=1.
  2. req[w]=1, lock[w]=1, burst_cnt<MAXBURST: hold. burst_cnt increments.
  3. req[w]=1, lock[w]=1, burst_cnt>=MAXBURST, no other req pending: hold. burst_cnt saturates at 15.
  4. req[w]=1, lock[w]=1, burst_cnt>=MAXBURST, another req pending: forced release. Grant passes to the next requester round-robin after w, burst_cnt=1.
  5. req[w]=1, lock[w]=0: single-cycle grant. If other requesters are pending, rotate to the next one after w. Otherwise keep w and increment burst_cnt.
- Output registers:
  - outflags and inflags are registered together with gnt: they equal src_sel/dst_sel of the requester whose gnt bit is set in the same cycle.
  - They are 0 when gnt=0.
  - They update every cycle while granted, so the owner may change codes during a burst.
- busy = |gnt, driven from a register.
- At most one gnt bit is ever high. A gnt bit never goes high for a requester whose req was low at the sampling edge.
- Reset asserted mid-burst: outputs clear immediately. The burst is not resumed; the requester must re-request.
- Any src_sel or dst_sel code is passed through unmodified; the arbiter does not check code legality.
- Simultaneous release and new request in the same cycle is handled as in rule 1: there is no lost cycle.

Optional Feature:
- Macro: BUS_ARB_CU_PRIO_EN.
- Defined:
  - Requester 0 wins every arbitration it participates in, ignoring rr.
  - In GRANT, a pending req[0] truncates any other owner's locked burst once that burst's burst_cnt>=2. The burst still holds for at least 2 cycles.
  - MAXBURST still applies to requester 0's own bursts only when another requester is waiting.
- Undefined: pure round-robin as above, with no preemption.

Test Plan:
- Reset: hold reset=0 with req=3'b111 toggling -> gnt=0, outflags=0, inflags=0, busy=0, burst_cnt=0 every cycle. On release, first grant goes to requester 0 one cycle after the first sampled req.
- Single requester: req=3'b010, src_sel[7:4]=4'h3, dst_sel[9:5]=5'h05, lock=0 -> next edge gnt=3'b010, outflags=3, inflags=5. After req drops, next edge gnt=0 and outflags=inflags=0.
- Round-robin: req=3'b111, lock=0 held for 6 cycles -> gnt sequence 001, 010, 100, 001, 010, 100.
- Burst limit: MAXBURST=4, req=3'b011, lock[0]=1 -> gnt=001 for exactly 4 cycles (burst_cnt 1..4), then 010. With req[1]=0, gnt stays 001 and burst_cnt saturates at 15.
- Back-to-back handoff: owner 1 drops req at the same edge req[2] rises -> gnt goes 010 to 100 with no zero cycle, burst_cnt=1.
- Mid-burst reset, with BUS_ARB_CU_PRIO_EN: owner 2 locked, req[0] rises at burst_cnt=1 -> grant moves to 001 after burst_cnt reaches 2. Then reset=0 mid-grant -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/bus_arb.sv
// bus_arb: registered round-robin arbiter for the 8-bit internal data bus.
//
// Requester 0 is the control unit, 1 the DMA/IO engine, 2 the debug port.
// Only the granted requester's driver/load codes reach the datapath.
// A granted requester may hold the bus with lock for up to MAXBURST cycles
// while others wait. With no one else waiting it may hold indefinitely.
//
// Optional feature macro: BUS_ARB_CU_PRIO_EN
//   defined   - requester 0 wins every arbitration it joins and truncates
//               other owners' locked bursts once they reach 2 cycles.
//   undefined - pure round-robin, no preemption.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   req        in   [NREQ]   per-requester bus request (level)
//   lock       in   [NREQ]   per-requester burst hold, used only while granted
//   src_sel    in   [NREQ*4] packed outflags codes, requester i at [4i+3:4i]
//   dst_sel    in   [NREQ*5] packed inflags codes, requester i at [5i+4:5i]
//   gnt        out  [NREQ]   one-hot grant, registered
//   outflags   out  [4]      bus driver select, 0 when no grant
//   inflags    out  [5]      bus load select, 0 when no grant
//   busy       out           any grant active, registered
//   burst_cnt  out  [4]      cycles in the current grant, saturating at 15
module bus_arb #(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned MAXBURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [NREQ*4-1:0] src_sel,
    input  logic [NREQ*5-1:0] dst_sel,
    output logic [NREQ-1:0]   gnt,
    output logic [3:0]        outflags,
    output logic [4:0]        inflags,
    output logic              busy,
    output logic [3:0]        burst_cnt
);

    localparam int unsigned SW = 4;
    localparam int unsigned DW = 5;
    localparam int unsigned CW = 4;
    localparam int unsigned IW = (NREQ > 2) ? 2 : 1;

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] BURST_LIM = CW'(MAXBURST);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      own_q, own_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [SW-1:0]      outflags_q, outflags_d;
    logic [DW-1:0]      inflags_q, inflags_d;
    logic               busy_q, busy_d;

    // Successor of requester i, wrapping at NREQ.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (i == IW'(NREQ - 1)) begin
            return '0;
        end
        return i + IW'(1);
    endfunction

    // First set bit of r scanning upward from start, wrapping at NREQ.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IW-1:0]   start);
        logic [IW-1:0]   res;
        logic            found;
        logic [NREQ-1:0] r_sh;
        int unsigned     idx;
        res   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(start) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            r_sh = r >> idx;
            if (!found && r_sh[0]) begin
                found = 1'b1;
                res   = IW'(idx);
            end
        end
        return res;
    endfunction

    // Arbitration winner; the control unit may override rotation.
    function automatic logic [IW-1:0] arb_pick(input logic [NREQ-1:0] r,
                                               input logic [IW-1:0]   start);
`ifdef BUS_ARB_CU_PRIO_EN
        if (r[0]) begin
            return '0;
        end
`endif
        return rr_pick(r, start);
    endfunction

    logic [NREQ-1:0] own_mask;
    logic [NREQ-1:0] others;
    logic            own_req;
    logic            own_lock;
    logic [IW-1:0]   nxt;
    logic [CW-1:0]   cnt_inc;
    logic            take;
    logic [IW-1:0]   win;
    logic [CW-1:0]   cnt_new;

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        own_d      = own_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        outflags_d = outflags_q;
        inflags_d  = inflags_q;
        busy_d     = busy_q;
        take       = 1'b0;
        win        = own_q;
        cnt_new    = CNT_ONE;

        own_mask = NREQ'(1) << own_q;
        others   = req & ~own_mask;
        own_req  = |(req & own_mask);
        own_lock = |(lock & own_mask);
        nxt      = next_idx(own_q);
        cnt_inc  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    take    = 1'b1;
                    win     = arb_pick(req, rr_q);
                    cnt_new = CNT_ONE;
                end
            end
            GRANT: begin
                if (!own_req) begin
                    // Release; re-arbitrate in the same edge so a waiting
                    // requester is granted without an idle bubble.
                    rr_d = nxt;
                    if (|req) begin
                        take    = 1'b1;
                        win     = arb_pick(req, nxt);
                        cnt_new = CNT_ONE;
                    end
`ifdef BUS_ARB_CU_PRIO_EN
                end else if ((own_q != '0) && req[0] && own_lock &&
                             (cnt_q >= CW'(2))) begin
                    // Control unit truncates another owner's locked burst.
                    rr_d    = nxt;
                    take    = 1'b1;
                    win     = '0;
                    cnt_new = CNT_ONE;
`endif
                end else if (own_lock && ((cnt_q < BURST_LIM) || !(|others))) begin
                    take    = 1'b1;
                    win     = own_q;
                    cnt_new = cnt_inc;
                end else if (|others) begin
                    // Forced release of an expired burst, or unlocked rotation.
                    rr_d    = nxt;
                    take    = 1'b1;
                    win     = arb_pick(others, nxt);
                    cnt_new = CNT_ONE;
                end else begin
                    take    = 1'b1;
                    win     = own_q;
                    cnt_new = cnt_inc;
                end
            end
            default: ;
        endcase

        // Codes are captured with the grant and refreshed every granted cycle.
        if (take) begin
            state_d    = GRANT;
            own_d      = win;
            cnt_d      = cnt_new;
            gnt_d      = NREQ'(1) << win;
            outflags_d = SW'(src_sel >> (32'(win) * 32'(SW)));
            inflags_d  = DW'(dst_sel >> (32'(win) * 32'(DW)));
            busy_d     = 1'b1;
        end else begin
            state_d    = IDLE;
            cnt_d      = '0;
            gnt_d      = '0;
            outflags_d = '0;
            inflags_d  = '0;
            busy_d     = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            own_q      <= '0;
            rr_q       <= '0;
            cnt_q      <= '0;
            gnt_q      <= '0;
            outflags_q <= '0;
            inflags_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            own_q      <= own_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            outflags_q <= outflags_d;
            inflags_q  <= inflags_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign outflags  = outflags_q;
    assign inflags   = inflags_q;
    assign busy      = busy_q;
    assign burst_cnt = cnt_q;

endmodule

// File: tb/tb_bus_arb.sv
// Directed testbench for bus_arb (NREQ=3, MAXBURST=4).
// Observed vector is {gnt, outflags, inflags, busy, burst_cnt}.
module tb_bus_arb;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  lock;
    logic [11:0] src_sel;
    logic [14:0] dst_sel;
    logic [2:0]  gnt;
    logic [3:0]  outflags;
    logic [4:0]  inflags;
    logic        busy;
    logic [3:0]  burst_cnt;

    int n_checks;
    int n_fail;

    logic [16:0] obs;
    assign obs = {gnt, outflags, inflags, busy, burst_cnt};

    bus_arb #(
        .NREQ     (3),
        .MAXBURST (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .lock      (lock),
        .src_sel   (src_sel),
        .dst_sel   (dst_sel),
        .gnt       (gnt),
        .outflags  (outflags),
        .inflags   (inflags),
        .busy      (busy),
        .burst_cnt (burst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        lock  = '0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [16:0] exp;
        reset   = 1'b0;
        lock    = '0;
        src_sel = 12'hCBA;
        dst_sel = {5'h13, 5'h12, 5'h11};
        for (int i = 0; i < 4; i++) begin
            req = (i % 2 == 0) ? 3'b111 : 3'b000;
            step();
            n_checks++;
            if (obs !== 17'h0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, obs, 17'h0);
            end
        end
        req   = 3'b111;
        reset = 1'b1;
        step();
        exp = {3'b001, 4'hA, 5'h11, 1'b1, 4'd1};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %h expected %h", obs, exp);
        end
        req = 3'b000;
        step();
        n_checks++;
        if (obs !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", obs, 17'h0);
        end
    endtask

    task automatic test_single();
        logic [16:0] exp;
        do_reset();
        src_sel = 12'h030;
        dst_sel = 15'h00A0;
        req     = 3'b010;
        lock    = 3'b000;
        step();
        exp = {3'b010, 4'h3, 5'h05, 1'b1, 4'd1};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL single_grant: got %h expected %h", obs, exp);
        end
        step();
        exp = {3'b010, 4'h3, 5'h05, 1'b1, 4'd2};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL single_keep: got %h expected %h", obs, exp);
        end
        src_sel = 12'h0E0;
        step();
        exp = {3'b010, 4'hE, 5'h05, 1'b1, 4'd3};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL single_code_change: got %h expected %h", obs, exp);
        end
        req = 3'b000;
        step();
        n_checks++;
        if (obs !== 17'h0) begin
            n_fail++;
            $display("FAIL single_release: got %h expected %h", obs, 17'h0);
        end
    endtask

    task automatic test_round_robin();
        int          own_seq [6];
        logic [16:0] exp;
`ifdef BUS_ARB_CU_PRIO_EN
        own_seq = '{0, 1, 0, 1, 0, 1};
`else
        own_seq = '{0, 1, 2, 0, 1, 2};
`endif
        do_reset();
        src_sel = 12'hCBA;
        dst_sel = {5'h13, 5'h12, 5'h11};
        req     = 3'b111;
        lock    = 3'b000;
        for (int i = 0; i < 6; i++) begin
            step();
            exp = {3'(3'b001 << own_seq[i]), 4'(4'hA + own_seq[i]),
                   5'(5'h11 + own_seq[i]), 1'b1, 4'd1};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL rr_seq[%0d]: got %h expected %h", i, obs, exp);
            end
        end
        req = 3'b000;
        step();
        n_checks++;
        if (obs !== 17'h0) begin
            n_fail++;
            $display("FAIL rr_release: got %h expected %h", obs, 17'h0);
        end
    endtask

    task automatic test_burst_limit();
        logic [16:0] exp;
        do_reset();
        src_sel = 12'hCBA;
        dst_sel = {5'h13, 5'h12, 5'h11};
        req     = 3'b011;
        lock    = 3'b001;
        for (int c = 1; c <= 4; c++) begin
            step();
            exp = {3'b001, 4'hA, 5'h11, 1'b1, 4'(c)};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL burst_hold[%0d]: got %h expected %h", c, obs, exp);
            end
        end
        step();
        exp = {3'b010, 4'hB, 5'h12, 1'b1, 4'd1};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL burst_forced_release: got %h expected %h", obs, exp);
        end
        req = 3'b001;
        step();
        exp = {3'b001, 4'hA, 5'h11, 1'b1, 4'd1};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL burst_regrant: got %h expected %h", obs, exp);
        end
        for (int c = 2; c <= 17; c++) begin
            step();
            exp = {3'b001, 4'hA, 5'h11, 1'b1, 4'((c > 15) ? 15 : c)};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL burst_saturate[%0d]: got %h expected %h", c, obs, exp);
            end
        end
        req  = 3'b000;
        lock = 3'b000;
        step();
        n_checks++;
        if (obs !== 17'h0) begin
            n_fail++;
            $display("FAIL burst_release: got %h expected %h", obs, 17'h0);
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] exp;
        do_reset();
        src_sel = 12'h765;
        dst_sel = {5'h1F, 5'h0F, 5'h01};
        req     = 3'b010;
        lock    = 3'b000;
        step();
        exp = {3'b010, 4'h6, 5'h0F, 1'b1, 4'd1};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL b2b_first: got %h expected %h", obs, exp);
        end
        req = 3'b100;
        step();
        exp = {3'b100, 4'h7, 5'h1F, 1'b1, 4'd1};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL b2b_handoff: got %h expected %h", obs, exp);
        end
        req = 3'b000;
        step();
        n_checks++;
        if (obs !== 17'h0) begin
            n_fail++;
            $display("FAIL b2b_release: got %h expected %h", obs, 17'h0);
        end
    endtask

    task automatic test_mid_reset();
        logic [16:0] exp;
        do_reset();
        src_sel = 12'h765;
        dst_sel = {5'h1F, 5'h0F, 5'h01};
        req     = 3'b001;
        lock    = 3'b001;
        step();
        step();
        exp = {3'b001, 4'h5, 5'h01, 1'b1, 4'd2};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL midrst_burst: got %h expected %h", obs, exp);
        end
        #3;
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs !== 17'h0) begin
            n_fail++;
            $display("FAIL midrst_async_clear: got %h expected %h", obs, 17'h0);
        end
        step();
        req   = 3'b000;
        lock  = 3'b000;
        reset = 1'b1;
        step();
        n_checks++;
        if (obs !== 17'h0) begin
            n_fail++;
            $display("FAIL midrst_no_resume: got %h expected %h", obs, 17'h0);
        end
        req = 3'b001;
        step();
        exp = {3'b001, 4'h5, 5'h01, 1'b1, 4'd1};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL midrst_rerequest: got %h expected %h", obs, exp);
        end
        req = 3'b000;
        step();
    endtask

`ifdef BUS_ARB_CU_PRIO_EN
    task automatic test_cu_prio();
        logic [16:0] exp;
        do_reset();
        src_sel = 12'h765;
        dst_sel = {5'h1F, 5'h0F, 5'h01};
        req     = 3'b100;
        lock    = 3'b100;
        step();
        req = 3'b101;
        step();
        exp = {3'b100, 4'h7, 5'h1F, 1'b1, 4'd2};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL prio_min_burst: got %h expected %h", obs, exp);
        end
        step();
        exp = {3'b001, 4'h5, 5'h01, 1'b1, 4'd1};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL prio_preempt: got %h expected %h", obs, exp);
        end
        #3;
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs !== 17'h0) begin
            n_fail++;
            $display("FAIL prio_async_clear: got %h expected %h", obs, 17'h0);
        end
        req   = 3'b000;
        lock  = 3'b000;
        step();
        reset = 1'b1;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        req      = '0;
        lock     = '0;
        src_sel  = '0;
        dst_sel  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_burst_limit();
        test_back_to_back();
        test_mid_reset();
`ifdef BUS_ARB_CU_PRIO_EN
        test_cu_prio();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
